// File: rtl/fsl_arbiter_if.sv
// Bundle of every FSL channel around the two-requester arbiter: requester inputs,
// accelerator request/response links, requester response outputs and status.
interface fsl_arbiter_if;
  logic [0:31] S0_Data;
  logic        S0_Control;
  logic        S0_Exists;
  logic        S0_Read;
  logic [0:31] S1_Data;
  logic        S1_Control;
  logic        S1_Exists;
  logic        S1_Read;
  logic [0:31] A_Data;
  logic        A_Control;
  logic        A_Write;
  logic        A_Full;
  logic [0:31] R_Data;
  logic        R_Control;
  logic        R_Exists;
  logic        R_Read;
  logic [0:31] M0_Data;
  logic        M0_Control;
  logic        M0_Write;
  logic        M0_Full;
  logic [0:31] M1_Data;
  logic        M1_Control;
  logic        M1_Write;
  logic        M1_Full;
  logic        Busy;
  logic        Grant;

  // Arbiter side.
  modport master (
    input  S0_Data, S0_Control, S0_Exists, output S0_Read,
    input  S1_Data, S1_Control, S1_Exists, output S1_Read,
    output A_Data, A_Control, A_Write, input A_Full,
    input  R_Data, R_Control, R_Exists, output R_Read,
    output M0_Data, M0_Control, M0_Write, input M0_Full,
    output M1_Data, M1_Control, M1_Write, input M1_Full,
    output Busy, Grant
  );

  // Environment side: requesters, accelerator and response sinks.
  modport slave (
    output S0_Data, S0_Control, S0_Exists, input S0_Read,
    output S1_Data, S1_Control, S1_Exists, input S1_Read,
    input  A_Data, A_Control, A_Write, output A_Full,
    output R_Data, R_Control, R_Exists, input R_Read,
    input  M0_Data, M0_Control, M0_Write, output M0_Full,
    input  M1_Data, M1_Control, M1_Write, output M1_Full,
    input  Busy, Grant
  );
endinterface

// File: rtl/fsl_arbiter.sv
// Round-robin sharing of one FSL accelerator between two requesters, one packet
// transaction in flight at a time. Define FSL_ARB_TIMEOUT_EN to add a response-timeout abort.
module fsl_arbiter #(
  parameter int PKT_WORDS = 8,
  parameter int RSP_WORDS = 8
`ifdef FSL_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic          FSL_Clk,
  input  logic          FSL_Rst,
  fsl_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    RSP   = 2'd2
`ifdef FSL_ARB_TIMEOUT_EN
    , ABORT = 2'd3
`endif
  } state_t;

  localparam logic [7:0] PKT_LAST = 8'(PKT_WORDS - 1);
  localparam logic [7:0] RSP_LAST = 8'(RSP_WORDS - 1);

  state_t     state_q, state_d;
  logic       grant_q, grant_d;
  logic       rr_last_q, rr_last_d;
  logic [7:0] wcnt_q, wcnt_d;

  logic s_exists_g;
  logic mg_full;
  logic fwd_xfer;
  logic rsp_xfer;

  assign s_exists_g = grant_q ? bus.S1_Exists : bus.S0_Exists;
  assign mg_full    = grant_q ? bus.M1_Full : bus.M0_Full;
  assign fwd_xfer   = (state_q == FWD) & s_exists_g & ~bus.A_Full;
  assign rsp_xfer   = (state_q == RSP) & bus.R_Exists & ~mg_full;

`ifdef FSL_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] idle_q, idle_d;
  logic        abort_xfer;
  assign abort_xfer = (state_q == ABORT) & ~mg_full;
`endif

  always_ff @(posedge FSL_Clk or negedge FSL_Rst) begin
    if (!FSL_Rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      rr_last_q <= 1'b1;
      wcnt_q    <= 8'd0;
`ifdef FSL_ARB_TIMEOUT_EN
      idle_q    <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      wcnt_q    <= wcnt_d;
`ifdef FSL_ARB_TIMEOUT_EN
      idle_q    <= idle_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    wcnt_d    = wcnt_q;
`ifdef FSL_ARB_TIMEOUT_EN
    idle_d    = idle_q;
`endif
    case (state_q)
      IDLE: begin
        // On a tie the requester that did not own the last transaction wins.
        if (bus.S0_Exists | bus.S1_Exists) begin
          grant_d = (bus.S0_Exists & bus.S1_Exists) ? ~rr_last_q : bus.S1_Exists;
          state_d = FWD;
        end
      end
      FWD: begin
        if (fwd_xfer) begin
          if (wcnt_q == PKT_LAST) begin
            wcnt_d  = 8'd0;
            state_d = RSP;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end
      end
      RSP: begin
        if (rsp_xfer) begin
`ifdef FSL_ARB_TIMEOUT_EN
          idle_d = 16'd0;
`endif
          if (wcnt_q == RSP_LAST) begin
            wcnt_d    = 8'd0;
            rr_last_d = grant_q;
            state_d   = IDLE;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end
`ifdef FSL_ARB_TIMEOUT_EN
        else if (idle_q == TO_LAST) begin
          idle_d  = 16'd0;
          wcnt_d  = 8'd0;
          state_d = ABORT;
        end else begin
          idle_d = idle_q + 16'd1;
        end
`endif
      end
`ifdef FSL_ARB_TIMEOUT_EN
      ABORT: begin
        if (abort_xfer) begin
          rr_last_d = grant_q;
          state_d   = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.S0_Read    = 1'b0;
    bus.S1_Read    = 1'b0;
    bus.A_Write    = 1'b0;
    bus.A_Data     = 32'd0;
    bus.A_Control  = 1'b0;
    bus.R_Read     = 1'b0;
    bus.M0_Write   = 1'b0;
    bus.M0_Data    = 32'd0;
    bus.M0_Control = 1'b0;
    bus.M1_Write   = 1'b0;
    bus.M1_Data    = 32'd0;
    bus.M1_Control = 1'b0;
    case (state_q)
      FWD: begin
        bus.A_Write = fwd_xfer;
        bus.S0_Read = fwd_xfer & ~grant_q;
        bus.S1_Read = fwd_xfer & grant_q;
        if (fwd_xfer) begin
          bus.A_Data    = grant_q ? bus.S1_Data : bus.S0_Data;
          bus.A_Control = grant_q ? bus.S1_Control : bus.S0_Control;
        end
      end
      RSP: begin
        bus.R_Read = rsp_xfer;
        if (grant_q) begin
          bus.M1_Write   = rsp_xfer;
          bus.M1_Data    = bus.R_Data;
          bus.M1_Control = bus.R_Control;
        end else begin
          bus.M0_Write   = rsp_xfer;
          bus.M0_Data    = bus.R_Data;
          bus.M0_Control = bus.R_Control;
        end
      end
`ifdef FSL_ARB_TIMEOUT_EN
      // Abort marker: all-ones word with control set, late accelerator words are left in place.
      ABORT: begin
        if (grant_q) begin
          bus.M1_Write   = abort_xfer;
          bus.M1_Data    = 32'hFFFF_FFFF;
          bus.M1_Control = 1'b1;
        end else begin
          bus.M0_Write   = abort_xfer;
          bus.M0_Data    = 32'hFFFF_FFFF;
          bus.M0_Control = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  assign bus.Busy  = (state_q != IDLE);
  assign bus.Grant = grant_q;

endmodule
